// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 16-bit CPU front end.
//   CPU_ADDR_W / CPU_DATA_W : default instruction address / word widths
//   fetch_state_e           : instruction fetch FSM states
//   fetch_entry_t           : one fetch buffer entry {addr, data}
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of fetched instructions (depth 1 or 2).
// Entry 0 is always the head; a pop shifts the remaining entries down.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : drop all entries (wins over push/pop)
//   push_i     : write din_i at the tail
//   pop_i      : remove the head entry
//   din_i      : entry to push
//   dout_o     : head entry
//   count_o    : number of valid entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  fetch_entry_t     din_i,
  output fetch_entry_t     dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     q_q [DEPTH];
  fetch_entry_t     q_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = q_q[0];

  // Over/underflow protection; a push into a full buffer is allowed only
  // when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      if (do_pop) begin
        for (int i = 1; i < DEPTH; i++) q_d[i-1] = q_q[i];
        cnt_d = cnt_d - CNT_W'(1);
      end
      // Tail index is taken after the pop so push+pop lands in the right slot.
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == cnt_d) q_d[i] = din_i;
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch unit.
// Reads from instruction memory at the PC, buffers returned words for the
// decoder and pulses pc_adv for every accepted fetch. flush discards the
// buffer and any in-flight read.
// Build option: FETCH_PREFETCH_EN defined -> 2-entry buffer, chained
// requests (one instruction per cycle); undefined -> 1-entry buffer.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   pc                  : address of the next fetch
//   pc_adv              : one-cycle pulse, program counter increments
//   flush               : drop buffered/in-flight words (pc already redirected)
//   mem_req, mem_addr   : read request, address stable while mem_req high
//   mem_ack, mem_rdata  : read completion and returned word
//   instr, instr_addr   : head-of-buffer instruction and its address
//   instr_valid         : head entry valid
//   instr_ready         : decoder accepts head entry
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  fetch_entry_t      buf_din, buf_dout;
  logic [CNT_W-1:0]  buf_cnt;
  logic              buf_full, buf_empty;
  logic              push, pop, space_ok;

  // flush outranks both the decoder pop and the memory push.
  assign pop  = !buf_empty && instr_ready && !flush;
  assign push = (state_q == REQ) && mem_ack && !flush && (!buf_full || pop);

  // Free slot left after this cycle's push/pop (push is 0 outside REQ).
  assign space_ok = (int'(buf_cnt) + int'(push) - int'(pop)) < DEPTH;

  assign buf_din.addr = mem_addr_q;
  assign buf_din.data = mem_rdata;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (buf_din),
    .dout_o  (buf_dout),
    .count_o (buf_cnt),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush && space_ok) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc;
          end
        end
        REQ: begin
          if (flush) begin
            // Acked data this cycle is simply not pushed; otherwise the
            // outstanding read must still be drained in DROP.
            if (mem_ack) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end else begin
              state_q   <= DROP;
            end
          end else if (mem_ack) begin
            if (space_ok) begin
              // pc increments on this edge, so the next address is pc+1.
              mem_addr_q <= pc + ADDR_W'(1);
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_adv      = push;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = buf_dout.data;
  assign instr_addr  = buf_dout.addr;
  assign instr_valid = !buf_empty;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the 16-bit CPU. It consumes the address driven by the program counter, issues single-outstanding read requests to instruction memory, and buffers returned words for the decoder through a valid/ready handshake. It also pulses an advance strobe back to the program counter for every accepted fetch, and drops in-flight and buffered words on a pipeline flush.

## Interface
Parameters:
- ADDR_W, 16, instruction address width
- DATA_W, 16, instruction word width

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pc  in  ADDR_W  current program-counter value, the address of the next fetch
- pc_adv  out  1  one-cycle pulse; the program counter increments on this pulse
- flush  in  1  discard buffered and in-flight instructions; pc already redirected
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  ADDR_W  read address, stable while mem_req is high
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  returned instruction word
- instr  out  DATA_W  head-of-buffer instruction
- instr_addr  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_addr valid
- instr_ready  in  1  decoder accepts head entry when instr_valid && instr_ready

## Operation
- Reset (rst_n low at clk edge): state IDLE, buffer empty, mem_req=0, mem_addr=0, pc_adv=0, instr_valid=0, instr=0, instr_addr=0.
- States:
  - IDLE: no request. Go to REQ when the buffer has free space, counted after any pop this cycle; latch mem_addr <= pc.
  - REQ: mem_req=1. On mem_ack, push {mem_rdata, mem_addr} and pulse pc_adv in the same cycle. Then go to REQ again with mem_addr <= pc+1 if space remains after the push/pop; otherwise go to IDLE.
  - DROP: mem_req=1, holding the old mem_addr until mem_ack. The acked data is discarded with no pc_adv. Then go to IDLE.
- Single outstanding request. mem_addr never changes while mem_req is high.
- Buffer is FIFO ordered. A pop and a push in the same cycle leave the count unchanged.
- flush in IDLE: buffer cleared, stay in IDLE.
- flush in REQ without mem_ack: buffer cleared, go to DROP.
- flush in REQ with mem_ack: data discarded, no pc_adv, buffer cleared, go to IDLE.
- flush in DROP: buffer cleared, stay in DROP.
- flush has priority over the decoder pop and over the push.
- Address arithmetic is modulo 2^ADDR_W. 16'hFFFF+1 wraps to 16'h0000.

## Timing
- Request issue: mem_req rises the cycle after the IDLE→REQ decision. The first request comes 1 cycle after rst_n is sampled high.
- mem_ack may arrive in the first cycle mem_req is high (zero wait) or any cycle later.
- Fetch latency: mem_ack in cycle N → instr_valid=1 in cycle N+1, if the buffer was empty.
- pc_adv is coincident with the accepted mem_ack. pc must reflect the increment by cycle N+1.
- After a flush, instr_valid=0 in the next cycle. The first post-flush request is issued the cycle after the flush, or the cycle after the dropped ack.
- Back-to-back with the prefetch buffer, with zero-wait memory and the decoder always ready: one instruction per cycle in steady state.

## Configuration
- FETCH_PREFETCH_EN defined: 2-entry buffer. A request may be issued while one entry is held, and requests chain REQ→REQ.
- FETCH_PREFETCH_EN undefined: 1-entry buffer. A request is issued only when the buffer is empty or being popped this cycle. Peak throughput is one instruction per 2 cycles. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W/DATA_W defaults
  - the fetch state enum {IDLE, REQ, DROP}
  - the buffer-entry struct {addr, data}
- One sub-module, fetch_buffer: a parameterized-depth FIFO with push, pop, clear, count, full and empty. Depth is 1 or 2, selected by the macro.
- instruction_fetch holds the FSM, the mem_addr register and the pc_adv logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release with pc=16'h0000 → all outputs 0 during reset; mem_req=1, mem_addr=16'h0000 one cycle after release.
- Zero-wait stream: mem_ack tied high, mem_rdata=addr^16'hA5A5, instr_ready=1 → instructions 0x0000..0x0009 arrive in order with correct instr_addr, one per cycle (prefetch) or one per 2 cycles (no prefetch), and exactly one pc_adv per instruction.
- Backpressure: instr_ready=0 for 10 cycles → at most 2 (or 1) entries buffered, no mem_req while full, mem_addr stable; release → no loss or duplication.
- Wait states: mem_ack delayed 3 cycles on address 16'h0004 → mem_req and mem_addr=16'h0004 held for 4 cycles; instr_valid for that word appears 1 cycle after the ack.
- Flush mid-request: flush while REQ to 16'h0010 is waiting, pc redirected to 16'h0100 → the 16'h0010 data is dropped with no pc_adv; the next request has mem_addr=16'h0100; no instr with addr 16'h0010 is ever presented.
- Wrap and simultaneous events: pc=16'hFFFF with flush and mem_ack in the same cycle → data discarded; after redirect to 16'hFFFF, the fetch of 16'hFFFF is followed by a fetch at 16'h0000.
